// File: rtl/prbs_pkg.sv
// Shared encodings and defaults for the PRBS Bernoulli event array.
package prbs_pkg;

  localparam int unsigned CHAN_W   = 6;
  localparam int unsigned CFG_SEL_W = 2;

  // Config write targets selected by cfg_sel_i.
  typedef enum logic [CFG_SEL_W-1:0] {
    CFG_THR  = 2'd0,
    CFG_SEED = 2'd1,
    CFG_MODE = 2'd2,
    CFG_CLR  = 2'd3
  } cfg_sel_e;

  // Comparator sense: GE fires when state >= thr, LT when state < thr.
  typedef enum logic {
    MODE_GE = 1'b0,
    MODE_LT = 1'b1
  } mode_e;

  // Default XNOR taps for a 32-bit register (bits 31, 30, 10, 0).
  localparam logic [31:0] TAP_MASK_32 = 32'hC000_0401;

endpackage

// File: rtl/prbs_lane.sv
// One channel: XNOR LFSR, threshold/mode registers, comparator and saturating counter.
module prbs_lane
  import prbs_pkg::*;
#(
  parameter int unsigned      LFSR_W     = 32,
  parameter int unsigned      CNT_W      = 16,
  parameter logic [LFSR_W-1:0] TAP_MASK  = LFSR_W'(TAP_MASK_32),
  parameter logic [LFSR_W-1:0] RST_STATE = '0,
  parameter logic [LFSR_W-1:0] THRESH_RST = LFSR_W'(2),
  parameter logic              MODE_RST  = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_i,
  input  logic              wr_thr_i,
  input  logic              wr_seed_i,
  input  logic              wr_mode_i,
  input  logic              wr_clr_i,
  input  logic [LFSR_W-1:0] cfg_data_i,
  output logic              event_o,
  output logic [CNT_W-1:0]  cnt_o
);

  logic [LFSR_W-1:0] state_q, state_d;
  logic [LFSR_W-1:0] thr_q, thr_d;
  mode_e             mode_q, mode_d;
  logic              event_q, event_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              fb;
  logic [LFSR_W-1:0] step;
  logic              hit;

  // Next-state for LFSR, config registers, event bit and counter.
  always_comb begin
    fb      = ~(^(state_q & TAP_MASK));
    step    = {fb, state_q[LFSR_W-1:1]};
    hit     = (mode_q == MODE_LT) ? (state_q < thr_q) : (state_q >= thr_q);

    state_d = state_q;
    thr_d   = thr_q;
    mode_d  = mode_q;
    event_d = event_q;
    cnt_d   = cnt_q;

    if (en_i) begin
      state_d = step;
      event_d = hit;
      if (hit && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    // All-ones is the XNOR lock-up state; store zero instead.
    if (wr_seed_i) begin
      state_d = (&cfg_data_i) ? '0 : cfg_data_i;
    end
    if (wr_thr_i) begin
      thr_d = cfg_data_i;
    end
    if (wr_mode_i) begin
      mode_d = mode_e'(cfg_data_i[0]);
    end
    if (wr_clr_i) begin
      cnt_d = '0;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RST_STATE;
      thr_q   <= THRESH_RST;
      mode_q  <= mode_e'(MODE_RST);
      event_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      thr_q   <= thr_d;
      mode_q  <= mode_d;
      event_q <= event_d;
      cnt_q   <= cnt_d;
    end
  end

  assign event_o = event_q;
  assign cnt_o   = cnt_q;

endmodule

// File: rtl/prbs_bernoulli_array.sv
// N-channel pseudo-random Bernoulli event generator with runtime configuration.
module prbs_bernoulli_array
  import prbs_pkg::*;
#(
  parameter int unsigned       N_CH       = 4,
  parameter int unsigned       LFSR_W     = 32,
  parameter logic [LFSR_W-1:0] TAP_MASK   = LFSR_W'(TAP_MASK_32),
  parameter logic [LFSR_W-1:0] SEED       = '0,
  parameter logic [LFSR_W-1:0] THRESH_RST = LFSR_W'(2),
  parameter logic              MODE_RST   = 1'b0,
  parameter int unsigned       CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en_i,
  input  logic                    cfg_valid_i,
  output logic                    cfg_ready_o,
  input  logic [CHAN_W-1:0]       cfg_chan_i,
  input  logic [CFG_SEL_W-1:0]    cfg_sel_i,
  input  logic [LFSR_W-1:0]       cfg_data_i,
  output logic [N_CH-1:0]         event_o,
  output logic                    event_vld_o,
  output logic [N_CH*CNT_W-1:0]   cnt_o
);

  logic ready_q, ready_d;
  logic vld_q, vld_d;

  logic            cfg_acc;
  cfg_sel_e        sel;
  logic [N_CH-1:0] wr_thr, wr_seed, wr_mode, wr_clr;

  // Config decode: one write strobe per channel and target; out-of-range channels match nothing.
  always_comb begin
    cfg_acc = cfg_valid_i & ready_q;
    sel     = cfg_sel_e'(cfg_sel_i);
    wr_thr  = '0;
    wr_seed = '0;
    wr_mode = '0;
    wr_clr  = '0;
    for (int unsigned c = 0; c < N_CH; c++) begin
      if (cfg_acc && (cfg_chan_i == CHAN_W'(c))) begin
        wr_thr[c]  = (sel == CFG_THR);
        wr_seed[c] = (sel == CFG_SEED);
        wr_mode[c] = (sel == CFG_MODE);
        wr_clr[c]  = (sel == CFG_CLR);
      end
    end
  end

  // Ready rises one clock after reset release; valid tracks the enable.
  always_comb begin
    ready_d = 1'b1;
    vld_d   = en_i;
  end

  // Handshake and valid registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      ready_q <= ready_d;
      vld_q   <= vld_d;
    end
  end

  assign cfg_ready_o = ready_q;
  assign event_vld_o = vld_q;

  for (genvar c = 0; c < N_CH; c++) begin : g_lane
    localparam logic [LFSR_W-1:0] SEED_C = LFSR_W'(SEED + LFSR_W'(c));
    localparam logic [LFSR_W-1:0] RST_C  = (&SEED_C) ? '0 : SEED_C;

    prbs_lane #(
      .LFSR_W     (LFSR_W),
      .CNT_W      (CNT_W),
      .TAP_MASK   (TAP_MASK),
      .RST_STATE  (RST_C),
      .THRESH_RST (THRESH_RST),
      .MODE_RST   (MODE_RST)
    ) u_lane (
      .clk        (clk),
      .rst_n      (rst_n),
      .en_i       (en_i),
      .wr_thr_i   (wr_thr[c]),
      .wr_seed_i  (wr_seed[c]),
      .wr_mode_i  (wr_mode[c]),
      .wr_clr_i   (wr_clr[c]),
      .cfg_data_i (cfg_data_i),
      .event_o    (event_o[c]),
      .cnt_o      (cnt_o[c*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_prbs_bernoulli_array.sv
// Self-checking bench for prbs_bernoulli_array against a behavioural model.
module tb_prbs_bernoulli_array;
  import prbs_pkg::*;

  localparam int unsigned N_CH   = 4;
  localparam int unsigned LFSR_W = 32;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;
  localparam logic [31:0] TAPS   = 32'hC000_0401;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  en_i;
  logic                  cfg_valid_i;
  logic                  cfg_ready_o;
  logic [5:0]            cfg_chan_i;
  logic [1:0]            cfg_sel_i;
  logic [LFSR_W-1:0]     cfg_data_i;
  logic [N_CH-1:0]       event_o;
  logic                  event_vld_o;
  logic [N_CH*CNT_W-1:0] cnt_o;

  always #5 clk = ~clk;

  prbs_bernoulli_array #(
    .N_CH       (N_CH),
    .LFSR_W     (LFSR_W),
    .TAP_MASK   (TAPS),
    .SEED       (32'h0),
    .THRESH_RST (32'd2),
    .MODE_RST   (1'b0),
    .CNT_W      (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en_i        (en_i),
    .cfg_valid_i (cfg_valid_i),
    .cfg_ready_o (cfg_ready_o),
    .cfg_chan_i  (cfg_chan_i),
    .cfg_sel_i   (cfg_sel_i),
    .cfg_data_i  (cfg_data_i),
    .event_o     (event_o),
    .event_vld_o (event_vld_o),
    .cnt_o       (cnt_o)
  );

  // Behavioural model
  logic [31:0] m_state [N_CH];
  logic [31:0] m_thr   [N_CH];
  bit          m_lt    [N_CH];
  int unsigned m_cnt   [N_CH];
  bit          m_event [N_CH];
  bit          m_vld;
  bit          m_ready;

  int n_pass  = 0;
  int n_total = 0;

  function automatic logic [31:0] next_state(input logic [31:0] s);
    int ones = 0;
    for (int i = 0; i < 32; i++) if (TAPS[i] && s[i]) ones++;
    return (s >> 1) | (((ones % 2) == 0) ? 32'h8000_0000 : 32'h0);
  endfunction

  function automatic bit fires(input int c);
    return m_lt[c] ? (m_state[c] < m_thr[c]) : (m_state[c] >= m_thr[c]);
  endfunction

  function automatic logic [N_CH-1:0] exp_event();
    logic [N_CH-1:0] v = '0;
    for (int c = 0; c < N_CH; c++) v[c] = m_event[c];
    return v;
  endfunction

  function automatic logic [N_CH*CNT_W-1:0] exp_cnt();
    logic [N_CH*CNT_W-1:0] v = '0;
    for (int c = 0; c < N_CH; c++) v[c*CNT_W +: CNT_W] = CNT_W'(m_cnt[c]);
    return v;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < N_CH; c++) begin
      m_state[c] = 32'(c);
      if (m_state[c] == 32'hFFFF_FFFF) m_state[c] = 32'h0;
      m_thr[c]   = 32'd2;
      m_lt[c]    = 1'b0;
      m_cnt[c]   = 0;
      m_event[c] = 1'b0;
    end
    m_vld   = 1'b0;
    m_ready = 1'b0;
  endtask

  // Drive one clock of stimulus and advance the model; returns 1 ns after the edge.
  task automatic cycle(input bit en, input bit valid, input int chan,
                       input logic [1:0] sel, input logic [31:0] data);
    bit acc;
    bit hit;
    en_i = en; cfg_valid_i = valid; cfg_chan_i = 6'(chan);
    cfg_sel_i = sel; cfg_data_i = data;
    @(posedge clk);
    acc = valid && m_ready;
    for (int c = 0; c < N_CH; c++) begin
      hit = fires(c);
      if (en) begin
        m_event[c] = hit;
        m_state[c] = next_state(m_state[c]);
        if (hit && m_cnt[c] < CNT_MAX) m_cnt[c]++;
      end
      if (acc && chan == c) begin
        case (sel)
          2'd0: m_thr[c] = data;
          2'd1: m_state[c] = (data == 32'hFFFF_FFFF) ? 32'h0 : data;
          2'd2: m_lt[c] = data[0];
          default: m_cnt[c] = 0;
        endcase
      end
    end
    m_vld   = en;
    m_ready = 1'b1;
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 0, 2'd0, 32'h0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en_i = 1'b0; cfg_valid_i = 1'b0; cfg_chan_i = '0; cfg_sel_i = '0; cfg_data_i = '0;
    model_reset();
    #12;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({cfg_ready_o, event_vld_o, event_o, cnt_o} !== '0)
      $display("FAIL reset_outputs: got rdy=%b vld=%b ev=%b cnt=%h, want all zero",
               cfg_ready_o, event_vld_o, event_o, cnt_o);
    else n_pass++;
    do_reset();
    idle();
    n_total++;
    if (cfg_ready_o !== 1'b1 || event_vld_o !== 1'b0)
      $display("FAIL ready_after_reset: got rdy=%b vld=%b, want rdy=1 vld=0", cfg_ready_o, event_vld_o);
    else n_pass++;
  endtask

  task automatic test_basic_sequence();
    logic [3:0] want = 4'b1110;  // cycle k expects want[k]: 0,1,1,1
    for (int k = 0; k < 4; k++) begin
      cycle(1'b1, 1'b0, 0, 2'd0, 32'h0);
      n_total++;
      if (event_o[0] !== want[k] || event_o !== exp_event() || event_vld_o !== 1'b1)
        $display("FAIL basic_event k=%0d: got ev=%b vld=%b, want ev0=%b ev=%b vld=1",
                 k, event_o, event_vld_o, want[k], exp_event());
      else n_pass++;
    end
    n_total++;
    if (cnt_o[CNT_W-1:0] !== 4'd3 || cnt_o !== exp_cnt())
      $display("FAIL basic_cnt0: got %h, want cnt0=3 all=%h", cnt_o, exp_cnt());
    else n_pass++;
  endtask

  task automatic test_lt_mode();
    logic [3:0] want = 4'b0001;  // 1,0,0,0
    do_reset();
    idle();
    cycle(1'b0, 1'b1, 0, CFG_MODE, 32'h1);
    for (int k = 0; k < 4; k++) begin
      cycle(1'b1, 1'b0, 0, 2'd0, 32'h0);
      n_total++;
      if (event_o[0] !== want[k] || event_o !== exp_event())
        $display("FAIL lt_event k=%0d: got ev=%b, want ev0=%b ev=%b", k, event_o, want[k], exp_event());
      else n_pass++;
    end
    n_total++;
    if (cnt_o[CNT_W-1:0] !== 4'd1)
      $display("FAIL lt_cnt0: got %0d, want 1", cnt_o[CNT_W-1:0]);
    else n_pass++;
  endtask

  task automatic test_seed_lockup();
    // ch1 probes state==0 via LT threshold 1
    cycle(1'b0, 1'b1, 1, CFG_SEED, 32'hFFFF_FFFF);
    cycle(1'b0, 1'b1, 1, CFG_MODE, 32'h1);
    cycle(1'b0, 1'b1, 1, CFG_THR,  32'h1);
    cycle(1'b1, 1'b0, 0, 2'd0, 32'h0);
    n_total++;
    if (event_o[1] !== 1'b1)
      $display("FAIL seed_zero: got ev1=%b, want 1", event_o[1]);
    else n_pass++;
    // Next state must be 0x80000000: probe with GE 0x80000000
    cycle(1'b0, 1'b1, 1, CFG_MODE, 32'h0);
    cycle(1'b0, 1'b1, 1, CFG_THR,  32'h8000_0000);
    cycle(1'b1, 1'b0, 0, 2'd0, 32'h0);
    n_total++;
    if (event_o[1] !== 1'b1 || m_state[1] !== 32'h4000_0000)
      $display("FAIL seed_step: got ev1=%b, want 1", event_o[1]);
    else n_pass++;
    cycle(1'b1, 1'b0, 0, 2'd0, 32'h0);
    n_total++;
    if (event_o[1] !== 1'b0 || event_o !== exp_event())
      $display("FAIL seed_step2: got ev=%b, want ev1=0 ev=%b", event_o, exp_event());
    else n_pass++;
  endtask

  task automatic test_enable_hold();
    logic [N_CH-1:0]       ev_hold;
    logic [N_CH*CNT_W-1:0] cnt_hold;
    for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 0, 2'd0, 32'h0);
    ev_hold  = exp_event();
    cnt_hold = exp_cnt();
    for (int k = 0; k < 5; k++) begin
      idle();
      n_total++;
      if (event_o !== ev_hold || cnt_o !== cnt_hold || event_vld_o !== 1'b0)
        $display("FAIL hold k=%0d: got ev=%b cnt=%h vld=%b, want ev=%b cnt=%h vld=0",
                 k, event_o, cnt_o, event_vld_o, ev_hold, cnt_hold);
      else n_pass++;
    end
    for (int k = 0; k < 4; k++) begin
      cycle(1'b1, 1'b0, 0, 2'd0, 32'h0);
      n_total++;
      if (event_o !== exp_event() || cnt_o !== exp_cnt() || event_vld_o !== 1'b1)
        $display("FAIL resume k=%0d: got ev=%b cnt=%h vld=%b, want ev=%b cnt=%h vld=1",
                 k, event_o, cnt_o, event_vld_o, exp_event(), exp_cnt());
      else n_pass++;
    end
  endtask

  task automatic test_saturation_clear();
    cycle(1'b0, 1'b1, 2, CFG_THR,  32'h0);
    cycle(1'b0, 1'b1, 3, CFG_MODE, 32'h1);
    cycle(1'b0, 1'b1, 3, CFG_THR,  32'h0);
    for (int k = 0; k < 20; k++) cycle(1'b1, 1'b0, 0, 2'd0, 32'h0);
    n_total++;
    if (cnt_o[2*CNT_W +: CNT_W] !== 4'd15 || event_o[2] !== 1'b1 || event_o[3] !== 1'b0)
      $display("FAIL saturate: got cnt2=%0d ev=%b, want cnt2=15 ev2=1 ev3=0",
               cnt_o[2*CNT_W +: CNT_W], event_o);
    else n_pass++;
    cycle(1'b1, 1'b1, 2, CFG_CLR, 32'hDEAD_BEEF);
    n_total++;
    if (cnt_o[2*CNT_W +: CNT_W] !== 4'd0 || event_o[2] !== 1'b1)
      $display("FAIL clear_override: got cnt2=%0d ev2=%b, want cnt2=0 ev2=1",
               cnt_o[2*CNT_W +: CNT_W], event_o[2]);
    else n_pass++;
    cycle(1'b1, 1'b0, 0, 2'd0, 32'h0);
    n_total++;
    if (cnt_o[2*CNT_W +: CNT_W] !== 4'd1 || cnt_o !== exp_cnt())
      $display("FAIL clear_recount: got cnt=%h, want cnt2=1 all=%h", cnt_o, exp_cnt());
    else n_pass++;
  endtask

  task automatic test_random();
    int errs = 0;
    bit en, valid;
    int chan;
    logic [1:0] sel;
    logic [31:0] data;
    for (int k = 0; k < 300; k++) begin
      en    = ($urandom_range(3) != 0);
      valid = ($urandom_range(2) == 0);
      chan  = ($urandom_range(9) == 0) ? 63 : int'($urandom_range(7));
      sel   = 2'($urandom_range(3));
      data  = ($urandom_range(7) == 0) ? 32'hFFFF_FFFF : $urandom;
      cycle(en, valid, chan, sel, data);
      n_total++;
      if (event_o !== exp_event() || cnt_o !== exp_cnt() ||
          event_vld_o !== m_vld || cfg_ready_o !== 1'b1) begin
        if (errs < 10)
          $display("FAIL random k=%0d: got ev=%b cnt=%h vld=%b rdy=%b, want ev=%b cnt=%h vld=%b rdy=1",
                   k, event_o, cnt_o, event_vld_o, cfg_ready_o, exp_event(), exp_cnt(), m_vld);
        errs++;
      end else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    logic [3:0] want = 4'b1110;
    for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 0, 2'd0, 32'h0);
    #3;
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({cfg_ready_o, event_vld_o, event_o, cnt_o} !== '0)
      $display("FAIL async_reset: got rdy=%b vld=%b ev=%b cnt=%h, want all zero",
               cfg_ready_o, event_vld_o, event_o, cnt_o);
    else n_pass++;
    en_i = 1'b0; cfg_valid_i = 1'b0;
    model_reset();
    #2;
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    for (int k = 0; k < 4; k++) begin
      cycle(1'b1, 1'b0, 0, 2'd0, 32'h0);
      n_total++;
      if (event_o[0] !== want[k] || event_o !== exp_event())
        $display("FAIL restart_event k=%0d: got ev=%b, want ev0=%b ev=%b", k, event_o, want[k], exp_event());
      else n_pass++;
    end
    n_total++;
    if (cnt_o[CNT_W-1:0] !== 4'd3)
      $display("FAIL restart_cnt0: got %0d, want 3", cnt_o[CNT_W-1:0]);
    else n_pass++;
  endtask

  initial begin
    en_i = 1'b0; cfg_valid_i = 1'b0; cfg_chan_i = '0; cfg_sel_i = '0; cfg_data_i = '0;
    model_reset();
    test_reset();
    test_basic_sequence();
    test_lt_mode();
    test_seed_lockup();
    test_enable_hold();
    test_saturation_clear();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/prbs_bernoulli_array.md
Name: prbs_bernoulli_array

Overview:
- N-channel stochastic event generator for the disease model. Each channel has its own LFSR and produces one pseudo-random Bernoulli event bit per enabled clock.
- Each channel compares its LFSR state against a runtime-programmable threshold, in GE or LT mode.
- Extends the single-channel fixed-threshold generator with: parametrised width and taps, runtime seed and threshold load, enable, lock-up protection, and per-channel saturating event counters.
- Sits between the host configuration path and the population-update logic, which consumes event_o.

Parameters:
- N_CH, 4, number of independent channels (1..64).
- LFSR_W, 32, LFSR and threshold width (8..64).
- TAP_MASK, 32'hC0000401, XNOR feedback tap positions in state[LFSR_W-1:0] (bits 31,30,10,0).
- SEED, 0, base reset seed; channel c resets to SEED+c, truncated to LFSR_W.
- THRESH_RST, 2, reset threshold for every channel.
- MODE_RST, 0, reset mode for every channel: 0 = event when state>=thr, 1 = event when state<thr.
- CNT_W, 16, width of each per-channel event counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- en_i  in  1  global advance enable.
- cfg_valid_i  in  1  config write strobe.
- cfg_ready_o  out  1  config write accepted.
- cfg_chan_i  in  6  target channel.
- cfg_sel_i  in  2  write target: 0 threshold, 1 seed, 2 mode (bit0 of data), 3 counter clear (data ignored).
- cfg_data_i  in  LFSR_W  write data.
- event_o  out  N_CH  registered event bits.
- event_vld_o  out  1  event_o valid this cycle.
- cnt_o  out  N_CH*CNT_W  per-channel event counts; channel c occupies bits [c*CNT_W +: CNT_W].

Behaviour:
- Reset (async assert, sync release):
  - state[c] = SEED+c; if that value is all-ones, use 0 instead (XNOR lock-up value).
  - thr = THRESH_RST; mode = MODE_RST.
  - event_o = 0, event_vld_o = 0, cnt_o = 0, cfg_ready_o = 0.
- cfg_ready_o goes to 1 on the first clock after reset release and stays 1.
- LFSR step on each clk edge with en_i=1:
  - fb = ~XOR(state & TAP_MASK)
  - state <= {fb, state[LFSR_W-1:1]} (feedback enters the MSB; shift toward the LSB).
- Event output, one-cycle latency: on the same edge that steps the LFSR, event_o[c] <= compare(pre-step state[c], thr[c], mode[c]), and event_vld_o <= 1.
- When en_i=0:
  - state, event_o and counters hold.
  - event_vld_o <= 0.
- Counter: when en_i=1 and the newly computed event bit is 1, cnt[c] increments and saturates at 2^CNT_W-1 (no wrap).
- Config write:
  - Accepted when cfg_valid_i and cfg_ready_o are both high; takes effect at that edge.
  - Compare/step on that same edge uses the old values; the new value is used from the next edge.
  - Seed write replaces the step for that channel on that edge. A seed of all-ones is stored as 0.
  - Counter-clear write forces that cnt to 0, overriding any increment on the same edge.
  - cfg_chan_i >= N_CH: the write is accepted and ignored.
- Thresholds are unsigned. thr=0 in GE mode gives a constant 1; thr=0 in LT mode gives a constant 0.
- Reset asserted mid-operation reverts all state to reset values immediately.

Decomposition:
- Shared package prbs_pkg holds:
  - the cfg_sel encodings (CFG_THR, CFG_SEED, CFG_MODE, CFG_CLR);
  - the mode encodings (MODE_GE, MODE_LT);
  - the default TAP_MASK constant for width 32.
- One sub-module, prbs_lane, contains one channel's LFSR, threshold/mode registers, comparator and counter. The top level instantiates N_CH lanes with a generate loop and handles config decode.

Test Plan:
- Reset with SEED=0, thr=2, GE, en_i=1 → ch0 state sequence 0x80000000, 0x40000000, 0x20000000, 0x90000000; event_o[0] = 0,1,1,1; cnt0=3 after 4 enabled cycles.
- Mode write to LT on ch0 at cycle 0, then the same run → event_o[0] = 1,0,0,0 from the following edge; cnt0 counts the 1s only.
- Seed write of 0xFFFFFFFF to ch1 → stored state 0; next step gives 0x80000000; no lock-up.
- Toggle en_i low for 5 cycles mid-run → state and cnt unchanged; event_vld_o=0; sequence resumes exactly where it stopped.
- CNT_W=4 with thr=0 in GE mode → cnt saturates at 15. A clear write on the same edge as an event → cnt=0.
- Assert rst_n low mid-sequence, between clock edges → all outputs go to reset values without waiting for clk; after release the ch0 sequence restarts at 0x80000000.
